// File: rtl/part3_alu_pkg.sv
// rtl/part3_alu_pkg.sv - opcode enumeration and default width for the part3 ALU
package part3_alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } alu_op_t;

endpackage

// File: rtl/part3_alu_core.sv
// rtl/part3_alu_core.sv - combinational ALU function; carry/overflow outputs under PART3_ALU_FLAGS_EN
module part3_alu_core
  import part3_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
`ifdef PART3_ALU_FLAGS_EN
  output logic             o_carry,
  output logic             o_ovf,
`endif
  output logic [WIDTH-1:0] o_result
);

  alu_op_t w_op;
  assign w_op = alu_op_t'(i_op);

`ifdef PART3_ALU_FLAGS_EN
  // One extra bit keeps the ADD carry-out and SUB borrow.
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub;
  assign w_add = {1'b0, i_src1} + {1'b0, i_src2};
  assign w_sub = {1'b0, i_src1} - {1'b0, i_src2};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    o_ovf    = 1'b0;
    case (w_op)
      OP_ADD: begin
        o_result = w_add[WIDTH-1:0];
        o_carry  = w_add[WIDTH];
        o_ovf    = (i_src1[WIDTH-1] == i_src2[WIDTH-1]) &&
                   (w_add[WIDTH-1] != i_src1[WIDTH-1]);
      end
      OP_SUB: begin
        o_result = w_sub[WIDTH-1:0];
        o_carry  = w_sub[WIDTH];
        o_ovf    = (i_src1[WIDTH-1] != i_src2[WIDTH-1]) &&
                   (w_sub[WIDTH-1] != i_src1[WIDTH-1]);
      end
      OP_SHL: begin
        o_result = {i_src1[WIDTH-2:0], 1'b0};
        o_carry  = i_src1[WIDTH-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_src1[WIDTH-1:1]};
        o_carry  = i_src1[0];
      end
      OP_AND: o_result = i_src1 & i_src2;
      OP_OR:  o_result = i_src1 | i_src2;
      OP_XOR: o_result = i_src1 ^ i_src2;
      OP_NOT: o_result = ~i_src1;
      default: o_result = '0;
    endcase
  end
`else
  always_comb begin
    o_result = '0;
    case (w_op)
      OP_ADD: o_result = i_src1 + i_src2;
      OP_SUB: o_result = i_src1 - i_src2;
      OP_SHL: o_result = {i_src1[WIDTH-2:0], 1'b0};
      OP_SHR: o_result = {1'b0, i_src1[WIDTH-1:1]};
      OP_AND: o_result = i_src1 & i_src2;
      OP_OR:  o_result = i_src1 | i_src2;
      OP_XOR: o_result = i_src1 ^ i_src2;
      OP_NOT: o_result = ~i_src1;
      default: o_result = '0;
    endcase
  end
`endif

endmodule

// File: rtl/part3_alu.sv
// rtl/part3_alu.sv - registered ALU top with enable/reset output stage; flags under PART3_ALU_FLAGS_EN
module part3_alu
  import part3_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             en,
  input  logic [2:0]       Op,
  output logic             zero,
  output logic [WIDTH-1:0] dst
`ifdef PART3_ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             ovf,
  output logic             neg
`endif
);

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_dst;
  logic             r_zero;

`ifdef PART3_ALU_FLAGS_EN
  logic w_carry;
  logic w_ovf;
  logic r_carry;
  logic r_ovf;
`endif

  part3_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_op    (Op),
    .i_src1  (src1),
    .i_src2  (src2),
`ifdef PART3_ALU_FLAGS_EN
    .o_carry (w_carry),
    .o_ovf   (w_ovf),
`endif
    .o_result(w_result)
  );

  // zero is computed from the incoming result so it always matches dst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dst  <= '0;
      r_zero <= 1'b1;
    end else if (en) begin
      r_dst  <= w_result;
      r_zero <= (w_result == '0);
    end
  end

  assign dst  = r_dst;
  assign zero = r_zero;

`ifdef PART3_ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (en) begin
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign neg   = r_dst[WIDTH-1];
`endif

endmodule

// File: tb/tb_part3_alu.sv
// tb/tb_part3_alu.sv - directed self-checking bench for part3_alu (flag checks when PART3_ALU_FLAGS_EN)
module tb_part3_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] src1;
  logic [7:0] src2;
  logic       en;
  logic [2:0] Op;
  logic       zero;
  logic [7:0] dst;
`ifdef PART3_ALU_FLAGS_EN
  logic       carry;
  logic       ovf;
  logic       neg;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  part3_alu #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .src1 (src1),
    .src2 (src2),
    .en   (en),
    .Op   (Op),
    .zero (zero),
    .dst  (dst)
`ifdef PART3_ALU_FLAGS_EN
    ,
    .carry(carry),
    .ovf  (ovf),
    .neg  (neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b);
    rst_n = r;
    en    = e;
    Op    = op;
    src1  = a;
    src2  = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; Op = 3'd0; src1 = 8'd0; src2 = 8'd0;
    #1;
    step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    chk("reset_dst", dst, 8'd0);
    chk("reset_zero", zero, 8'd1);

    step(1'b1, 1'b0, 3'd0, 8'd4, 8'd5);
    chk("idle_dst", dst, 8'd0);
    chk("idle_zero", zero, 8'd1);

    step(1'b1, 1'b1, 3'd0, 8'd4, 8'd5);
    chk("add_4_5", dst, 8'd9);
    chk("add_4_5_zero", zero, 8'd0);

    step(1'b1, 1'b1, 3'd1, 8'd10, 8'd10);
    chk("sub_10_10", dst, 8'd0);
    chk("sub_10_10_zero", zero, 8'd1);

    step(1'b1, 1'b1, 3'd0, 8'd255, 8'd1);
    chk("add_wrap", dst, 8'd0);
    chk("add_wrap_zero", zero, 8'd1);

    step(1'b1, 1'b1, 3'd1, 8'd0, 8'd1);
    chk("sub_wrap", dst, 8'd255);
    chk("sub_wrap_zero", zero, 8'd0);

    step(1'b1, 1'b1, 3'd2, 8'd46, 8'd99);
    chk("shl_46", dst, 8'd92);

    step(1'b1, 1'b1, 3'd3, 8'd10, 8'd99);
    chk("shr_10", dst, 8'd5);

    step(1'b1, 1'b1, 3'd3, 8'h81, 8'h00);
    chk("shr_81", dst, 8'h40);

    step(1'b1, 1'b1, 3'd2, 8'h80, 8'hFF);
    chk("shl_80", dst, 8'h00);
    chk("shl_80_zero", zero, 8'd1);

    step(1'b1, 1'b1, 3'd4, 8'h55, 8'hF0);
    chk("and", dst, 8'h50);

    step(1'b1, 1'b1, 3'd5, 8'h55, 8'hF0);
    chk("or", dst, 8'hF5);

    step(1'b1, 1'b1, 3'd6, 8'h55, 8'hF0);
    chk("xor", dst, 8'hA5);
    chk("xor_zero", zero, 8'd0);

    step(1'b1, 1'b1, 3'd7, 8'hFF, 8'h12);
    chk("not_ff", dst, 8'h00);
    chk("not_ff_zero", zero, 8'd1);

    step(1'b1, 1'b1, 3'd7, 8'h0F, 8'h00);
    chk("not_0f", dst, 8'hF0);

    step(1'b1, 1'b1, 3'd0, 8'd4, 8'd5);
    chk("hold_setup", dst, 8'd9);
    step(1'b1, 1'b0, 3'd1, 8'd7, 8'd7);
    chk("hold_1", dst, 8'd9);
    step(1'b1, 1'b0, 3'd7, 8'hFF, 8'h00);
    chk("hold_2", dst, 8'd9);
    step(1'b1, 1'b0, 3'd4, 8'h00, 8'h00);
    chk("hold_3", dst, 8'd9);
    chk("hold_3_zero", zero, 8'd0);

    step(1'b0, 1'b1, 3'd0, 8'd20, 8'd30);
    chk("rst_prio_dst", dst, 8'd0);
    chk("rst_prio_zero", zero, 8'd1);

`ifdef PART3_ALU_FLAGS_EN
    chk("rst_carry", carry, 8'd0);
    chk("rst_ovf", ovf, 8'd0);

    step(1'b1, 1'b1, 3'd0, 8'h7F, 8'h01);
    chk("fl_add_dst", dst, 8'h80);
    chk("fl_add_ovf", ovf, 8'd1);
    chk("fl_add_neg", neg, 8'd1);
    chk("fl_add_carry", carry, 8'd0);

    step(1'b1, 1'b1, 3'd1, 8'd3, 8'd5);
    chk("fl_sub_dst", dst, 8'hFE);
    chk("fl_sub_carry", carry, 8'd1);
    chk("fl_sub_ovf", ovf, 8'd0);

    step(1'b1, 1'b0, 3'd4, 8'h00, 8'h00);
    chk("fl_hold_carry", carry, 8'd1);

    step(1'b1, 1'b1, 3'd2, 8'h80, 8'h00);
    chk("fl_shl_carry", carry, 8'd1);
    chk("fl_shl_neg", neg, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
